// File: rtl/td4_reg_scanner_if.sv
// Character-write port from the TD4 register scanner into the LCD text engine.
interface td4_reg_scanner_if;
    logic       char_valid;
    logic       char_ready;
    logic [3:0] char_addr;
    logic [7:0] char_data;
    logic       frame_done;

    modport master (
        output char_valid,
        output char_addr,
        output char_data,
        output frame_done,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_addr,
        input  char_data,
        input  frame_done,
        output char_ready
    );
endinterface

// File: rtl/td4_reg_scanner.sv
// Steps the TD4 debug selector through PC/A/B/C/OUT/IN and streams each view as a
// label + hex digit pair into the LCD character buffer, one frame per refresh period.
//
// state  | meaning
// IDLE   | refresh timer runs; next frame starts at terminal count unless hold
// SELECT | regsel driven, waiting SETTLE+1 cycles before sampling regdat
// LABEL  | offering the field label character at cell 2i
// DIGIT  | offering the hex digit of the sampled value at cell 2i+1
module td4_reg_scanner #(
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned REFRESH_DIV = 1000000
) (
    input  logic              CLOCK,
    input  logic              RESET,
    output logic [2:0]        regsel,
    input  logic [3:0]        regdat,
    input  logic              hold,
    td4_reg_scanner_if.master char_if
);
    localparam int unsigned RW = $clog2(REFRESH_DIV + 1);
    localparam int unsigned SW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LABEL,
        ST_DIGIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [RW-1:0] ref_cnt;
    logic [SW-1:0] set_cnt;
    logic [2:0]    fld;
    logic [3:0]    sample;
    logic          frame_done_q;
    logic          xfer;
    logic          start;
    logic          last_fld;
    logic [7:0]    label_chr;
    logic [7:0]    hex_chr;

    assign xfer     = char_if.char_valid && char_if.char_ready;
    assign start    = (ref_cnt == '0) && !hold;
    assign last_fld = (fld == 3'd5);
    assign regsel   = fld;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SELECT;
            ST_SELECT: if (set_cnt == '0) state_nxt = ST_LABEL;
            ST_LABEL:  if (xfer) state_nxt = ST_DIGIT;
            ST_DIGIT:  if (xfer) state_nxt = last_fld ? ST_IDLE : ST_SELECT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Refresh timer resets to terminal so the first frame after reset starts at once.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ref_cnt      <= '0;
            set_cnt      <= '0;
            fld          <= 3'd0;
            sample       <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= (state == ST_DIGIT) && xfer && last_fld;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        fld     <= 3'd0;
                        set_cnt <= SW'(SETTLE);
                    end else if (ref_cnt != '0) begin
                        ref_cnt <= ref_cnt - 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (set_cnt == '0) begin
                        sample <= regdat;
                    end else begin
                        set_cnt <= set_cnt - 1'b1;
                    end
                end
                ST_DIGIT: begin
                    if (xfer) begin
                        if (last_fld) begin
                            ref_cnt <= RW'(REFRESH_DIV);
                        end else begin
                            fld     <= fld + 3'd1;
                            set_cnt <= SW'(SETTLE);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (fld)
            3'd0:    label_chr = 8'h50;
            3'd1:    label_chr = 8'h41;
            3'd2:    label_chr = 8'h42;
            3'd3:    label_chr = 8'h43;
            3'd4:    label_chr = 8'h4F;
            default: label_chr = 8'h49;
        endcase
        hex_chr = (sample < 4'd10) ? (8'h30 + {4'd0, sample}) : (8'h37 + {4'd0, sample});
    end

    always_comb begin
        char_if.char_valid = 1'b0;
        char_if.char_addr  = 4'd0;
        char_if.char_data  = 8'h20;
        char_if.frame_done = frame_done_q;
        case (state)
            ST_LABEL: begin
                char_if.char_valid = 1'b1;
                char_if.char_addr  = {fld, 1'b0};
                char_if.char_data  = label_chr;
            end
            ST_DIGIT: begin
                char_if.char_valid = 1'b1;
                char_if.char_addr  = {fld, 1'b1};
                char_if.char_data  = hex_chr;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_td4_reg_scanner.sv
// Randomized scoreboard bench for td4_reg_scanner: expected character writes are
// queued per frame from a register-view model and checked by an independent monitor.
module tb_td4_reg_scanner;
    localparam int SETTLE      = 2;
    localparam int REFRESH_DIV = 8;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [2:0] regsel;
    logic [3:0] regdat;
    logic       hold;

    td4_reg_scanner_if u_if ();

    td4_reg_scanner #(
        .SETTLE      (SETTLE),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .regsel  (regsel),
        .regdat  (regdat),
        .hold    (hold),
        .char_if (u_if)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [3:0] core_regs [6];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         st = 0;
    logic [2:0] prev_sel = 3'd0;
    bit         perturb = 1'b0;
    bit         rdy_random = 1'b0;
    bit         rdy_fixed = 1'b1;

    function automatic logic [3:0] view(input logic [2:0] s);
        if (s < 3'd6) return core_regs[s];
        return 4'h0;
    endfunction

    // After the sample edge, perturbation mode corrupts the view so a late sample shows up.
    assign regdat = (perturb && st > SETTLE + 1) ? ~view(regsel) : view(regsel);

    always @(posedge CLOCK) begin
        cyc++;
        #1;
        if (regsel !== prev_sel) st = 1;
        else st++;
        prev_sel = regsel;
    end

    always @(posedge CLOCK) begin
        #2;
        u_if.char_ready = rdy_random ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        int c;
        c = (n < 10) ? 48 + int'(n) : 65 + int'(n) - 10;
        return 8'(c);
    endfunction

    task automatic push_frame();
        string lbl = "PABCOI";
        wr_t   w;
        for (int i = 0; i < 6; i++) begin
            w.addr = 4'(2 * i);
            w.data = lbl[i];
            exp_q.push_back(w);
            w.addr = 4'(2 * i + 1);
            w.data = hexc(core_regs[i]);
            exp_q.push_back(w);
        end
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < 6; i++) core_regs[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_neg();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic wait_fd(input string tag);
        int n = 0;
        do begin
            wait_neg();
            n++;
        end while (!u_if.frame_done && n < 600);
        chk({tag, " frame_done seen"}, 32'(u_if.frame_done), 32'd1);
    endtask

    task automatic wait_wr(input logic [3:0] a, input string tag);
        int n = 0;
        do begin
            wait_neg();
            n++;
        end while (!(u_if.char_valid && u_if.char_addr == a) && n < 200);
        chk({tag, " write offered"}, 32'(u_if.char_valid && u_if.char_addr == a), 32'd1);
    endtask

    // Monitor: pops expectations on transfers, checks stall stability and select timing.
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       pfd = 1'b0;
    logic [3:0] pa = 4'd0;
    logic [7:0] pd = 8'd0;

    always @(negedge CLOCK) begin
        wr_t w;
        if (!RESET) begin
            if (pv && !pr) begin
                chk("stall valid held", 32'(u_if.char_valid), 32'd1);
                chk("stall addr held", 32'(u_if.char_addr), 32'(pa));
                chk("stall data held", 32'(u_if.char_data), 32'(pd));
            end
            if (u_if.char_valid && !pv) begin
                chk("regsel stable before sample", 32'(st >= SETTLE + 2), 32'd1);
                chk("regsel matches field", 32'(regsel), 32'(u_if.char_addr[3:1]));
            end
            if (u_if.char_valid && u_if.char_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected write: addr=%0d data=0x%0h, want no write",
                             u_if.char_addr, u_if.char_data);
                end else begin
                    w = exp_q.pop_front();
                    chk("write addr", 32'(u_if.char_addr), 32'(w.addr));
                    chk("write data", 32'(u_if.char_data), 32'(w.data));
                end
            end
            if (u_if.frame_done) begin
                chk("writes left at frame_done", 32'(exp_q.size()), 32'd0);
                chk("frame_done single cycle", 32'(pfd), 32'd0);
            end
        end
        pv  = u_if.char_valid;
        pr  = u_if.char_ready;
        pa  = u_if.char_addr;
        pd  = u_if.char_data;
        pfd = u_if.frame_done;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int cnt;
        RESET = 1'b1;
        hold  = 1'b0;
        u_if.char_ready = 1'b1;
        core_regs[0] = 4'h3;
        core_regs[1] = 4'hA;
        core_regs[2] = 4'h0;
        core_regs[3] = 4'h1;
        core_regs[4] = 4'h7;
        core_regs[5] = 4'hF;
        wait_neg();
        wait_neg();
        chk("reset regsel", 32'(regsel), 32'd0);
        chk("reset char_valid", 32'(u_if.char_valid), 32'd0);
        chk("reset char_addr", 32'(u_if.char_addr), 32'd0);
        chk("reset char_data", 32'(u_if.char_data), 32'h20);
        chk("reset frame_done", 32'(u_if.frame_done), 32'd0);

        // Directed frame timing with ready tied high
        push_frame();
        RESET = 1'b0;
        wait_wr(4'd0, "first label");
        t0 = cyc;
        wait_fd("timing frame 1");
        chk("label0 to frame_done cycles", 32'(cyc - t0), 32'(6 * (SETTLE + 3) - (SETTLE + 1)));
        t0 = cyc;
        push_frame();
        wait_wr(4'd0, "next frame label");
        chk("frame_done to next label0 cycles", 32'(cyc - t0), 32'(REFRESH_DIV + 1 + SETTLE + 1));
        wait_fd("timing frame 2");

        // Random back-pressure
        rdy_random = 1'b1;
        for (int f = 0; f < 3; f++) begin
            if (f > 0) randomize_regs();
            push_frame();
            wait_fd("random ready");
        end
        rdy_random = 1'b0;
        rdy_fixed  = 1'b1;

        // regdat changes right after each sample edge
        perturb = 1'b1;
        for (int f = 0; f < 2; f++) begin
            randomize_regs();
            push_frame();
            wait_fd("perturbed regdat");
        end
        perturb = 1'b0;

        // hold raised mid-frame
        randomize_regs();
        push_frame();
        wait_wr(4'd4, "hold point");
        hold = 1'b1;
        wait_fd("held frame");
        cnt = 0;
        for (int k = 0; k < 3 * REFRESH_DIV + 5; k++) begin
            wait_neg();
            if (u_if.char_valid || regsel != 3'd5) cnt++;
        end
        chk("activity while held", 32'(cnt), 32'd0);
        push_frame();
        hold = 1'b0;
        wait_neg();
        chk("regsel right after hold release", 32'(regsel), 32'd0);
        wait_fd("after hold");

        // Reset during a stalled DIGIT of field 3
        randomize_regs();
        push_frame();
        wait_wr(4'd6, "reset point");
        rdy_fixed = 1'b0;
        wait_neg();
        wait_neg();
        chk("stalled on field 3 digit", 32'(u_if.char_valid && u_if.char_addr == 4'd7), 32'd1);
        RESET = 1'b1;
        exp_q.delete();
        wait_neg();
        chk("mid-frame reset char_valid", 32'(u_if.char_valid), 32'd0);
        chk("mid-frame reset regsel", 32'(regsel), 32'd0);
        chk("mid-frame reset char_data", 32'(u_if.char_data), 32'h20);
        chk("mid-frame reset char_addr", 32'(u_if.char_addr), 32'd0);
        rdy_fixed = 1'b1;
        push_frame();
        RESET = 1'b0;
        wait_fd("after reset");

        // Hex sweep of the PC view
        for (int pc = 0; pc < 16; pc++) begin
            randomize_regs();
            core_regs[0] = 4'(pc);
            push_frame();
            wait_fd("hex sweep");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
